// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci arbiter slice.
// Holds the sequencer state encoding, the largest index the core can
// evaluate without overflowing its result width, and the default widths
// that match the fibonacci core.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fib_arb_state_t;

  // fib(30) = 832040 is the last value that fits in a 20-bit result.
  localparam int FIB_MAX_IDX = 30;
  localparam int FIB_IDX_W   = 5;
  localparam int FIB_F_W     = 20;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Picks the first asserted request at or after ptr, wrapping modulo N.
// Ports:
//   req      - request vector
//   ptr      - index that currently has the highest priority
//   grant    - one-hot grant (all zero when nothing is requested)
//   grant_id - binary index of the granted request (0 when none)
module rr_arbiter
  import fib_pkg::*;
#(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = ID_W'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_id    = cand;
      end
    end
  end

endmodule

// File: rtl/fib_arbiter.sv
// Shares one fibonacci core among N_REQ requesters.
// One transaction at a time: a round-robin grant in IDLE, a start strobe to
// the core in START, result capture in WAIT, and a held response in RESP.
// Indices above FIB_MAX_IDX skip the core and answer with err=1, f=0.
//
// Handshakes:
//   req  : req_ready is a one-cycle combinational pulse in IDLE to the granted
//          requester; req_valid is not sticky and may drop at any time before.
//   rsp  : rsp_valid is held with stable rsp_id/rsp_f/rsp_err until the cycle
//          where rsp_valid && rsp_ready, which completes the transfer.
//   core : core_start pulses for one cycle while core_ready is high; the
//          result is taken only in the core_done_tick cycle.
//
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   req_valid/req_idx  - per-requester request and packed indices
//   req_ready          - one-hot accept pulse
//   rsp_valid/rsp_ready/rsp_id/rsp_f/rsp_err - shared response channel
//   core_start/core_i  - start strobe and index to the core
//   core_ready/core_done_tick/core_f - core status and result
//   dbg_state          - current sequencer state
module fib_arbiter
  import fib_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = FIB_IDX_W,
  parameter int F_W   = FIB_F_W,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*IDX_W-1:0] req_idx,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [F_W-1:0]         rsp_f,
  output logic                   rsp_err,
  output logic                   core_start,
  output logic [IDX_W-1:0]       core_i,
  input  logic                   core_ready,
  input  logic                   core_done_tick,
  input  logic [F_W-1:0]         core_f,
  output fib_arb_state_t         dbg_state
);

  fib_arb_state_t   state, state_next;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  id_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [F_W-1:0]   f_reg;
  logic             err_reg;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_oor;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_idx = req_idx[int'(grant_id)*IDX_W +: IDX_W];
  assign sel_oor = (32'(sel_idx) > 32'(FIB_MAX_IDX));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    core_start = 1'b0;
    core_i     = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) state_next = sel_oor ? RESP : START;
      end
      START: begin
        if (core_ready) begin
          core_start = 1'b1;
          core_i     = idx_reg;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (core_done_tick) state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      id_reg  <= '0;
      idx_reg <= '0;
      f_reg   <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            id_reg  <= grant_id;
            idx_reg <= sel_idx;
            f_reg   <= '0;
            err_reg <= sel_oor;
          end
        end
        WAIT: begin
          if (core_done_tick) begin
            f_reg   <= core_f;
            err_reg <= 1'b0;
          end
        end
        RESP: begin
          // Priority moves just past the requester that was served.
          if (rsp_ready)
            ptr <= (id_reg == ID_W'(N_REQ - 1)) ? '0 : id_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_reg;
  assign rsp_f     = f_reg;
  assign rsp_err   = err_reg;
  assign dbg_state = state;

endmodule
